// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the PWM-side pipeline stages.
//   DUTY_W       - width of the PWM duty value
//   PHASE_MAX    - last phase value of the 256-clock PWM period
//   ramp_state_t - duty_ramp FSM states
//   step_toward  - one saturating slew step from the current duty toward a target
package pwm_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] PHASE_MAX = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Move cur toward tgt by at most step. The difference is taken as a 9-bit
  // signed value so that the full 0..255 range is covered without wrap, and
  // the applied magnitude is clamped to the remaining distance, so the
  // result lands exactly on tgt rather than overshooting it.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic signed [DUTY_W:0] diff;
    logic [DUTY_W:0] mag;
    logic [DUTY_W:0] lim;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
    lim  = (mag < {1'b0, step}) ? mag : {1'b0, step};
    if (diff[DUTY_W]) begin
      return cur - lim[DUTY_W-1:0];
    end
    return cur + lim[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/duty_ramp_period_timer.sv
// period_timer: free-running 8-bit phase counter mirroring the 256-clock PWM
// period, with a one-cycle period_start pulse on the last clock of each period.
//   clk          - PWM clock
//   reset        - synchronous, active-high; phase returns to 0
//   period_start - high while phase == 255
module period_timer
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic period_start
);

  logic [DUTY_W-1:0] phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else begin
      phase <= phase + 8'd1;  // natural wrap 255 -> 0
    end
  end

  // Decoded from the phase register, so it is glitch-free and 0 in reset.
  assign period_start = (phase == PHASE_MAX);

endmodule

// File: rtl/duty_ramp.sv
// duty_ramp: accepts a target duty over valid/ready and slews the PWM duty
// toward it by at most STEP every PERIODS_PER_STEP PWM periods. duty only
// changes on the edge where the phase wraps 255 -> 0, so the PWM never sees
// a mid-period change.
//   clk          - clock shared with the PWM block
//   reset        - synchronous, active-high
//   target       - requested duty (0..255)
//   target_valid - target is presented
//   target_ready - block can accept a target (IDLE)
//   duty         - registered duty value for the PWM
//   period_start - one-cycle pulse on the last clock of each PWM period
//   busy         - a ramp is in progress (RAMP)
//
// Handshake: a target transfers on any clock edge where target_valid and
// target_ready are both high. target_ready is high exactly in IDLE; while
// ramping it is low and target_valid is ignored, so a ramp cannot be
// retargeted. A target equal to the current duty still transfers but leaves
// the block in IDLE.
module duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned STEP             = 1,
  parameter int unsigned PERIODS_PER_STEP = 4,
  parameter int unsigned RESET_DUTY       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic              target_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] STEP_V     = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] PPS_LAST   = DUTY_W'(PERIODS_PER_STEP - 1);
  localparam logic [DUTY_W-1:0] RESET_D    = DUTY_W'(RESET_DUTY);

  ramp_state_t       state;
  logic [DUTY_W-1:0] tgt_q;
  logic [DUTY_W-1:0] per_cnt;
  logic [DUTY_W-1:0] duty_next;

  period_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .period_start (period_start)
  );

  assign duty_next = step_toward(duty, tgt_q, STEP_V);

  // busy and target_ready are registered copies of the state decode, updated
  // on the same edges as state so they always agree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      duty         <= RESET_D;
      tgt_q        <= RESET_D;
      per_cnt      <= '0;
      target_ready <= 1'b1;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (target_valid && target_ready) begin
            tgt_q   <= target;
            per_cnt <= '0;
            if (target != duty) begin
              state        <= RAMP;
              target_ready <= 1'b0;
              busy         <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (period_start) begin
            if (per_cnt == PPS_LAST) begin
              per_cnt <= '0;
              duty    <= duty_next;
              // Leave RAMP on the very edge that lands on the target.
              if (duty_next == tgt_q) begin
                state        <= IDLE;
                target_ready <= 1'b1;
                busy         <= 1'b0;
              end
            end else begin
              per_cnt <= per_cnt + 8'd1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          target_ready <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: directed bench for duty_ramp. One instance uses STEP=8,
// PERIODS_PER_STEP=1; a second uses the default parameters.
module tb_duty_ramp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] target, target_d;
  logic       target_valid, target_valid_d;
  logic       target_ready, target_ready_d;
  logic [7:0] duty, duty_d;
  logic       period_start, period_start_d;
  logic       busy, busy_d;

  duty_ramp #(.STEP(8), .PERIODS_PER_STEP(1), .RESET_DUTY(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .duty         (duty),
    .period_start (period_start),
    .busy         (busy)
  );

  duty_ramp dut_d (
    .clk          (clk),
    .reset        (reset),
    .target       (target_d),
    .target_valid (target_valid_d),
    .target_ready (target_ready_d),
    .duty         (duty_d),
    .period_start (period_start_d),
    .busy         (busy_d)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the selected instance's duty to move away from prev.
  task automatic wait_change(input bit sel, input logic [7:0] prev, input int limit,
                             output int cyc, output bit ok);
    logic [7:0] cur;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit) begin
      tick();
      cyc++;
      cur = sel ? duty_d : duty;
      if (cur != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  target;
    int          n;      // number of duty changes expected (0 = equal target)
    logic [63:0] seq;    // element i in bits [8*i +: 8]
  } ramp_vec_t;

  ramp_vec_t vecs [5];

  task automatic run_vec(input ramp_vec_t v, input string tag);
    logic [7:0] prev;
    int  cyc;
    bit  ok;
    chk({tag, "_ready_pre"}, int'(target_ready), 1);
    prev         = duty;
    target       = v.target;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    chk({tag, "_busy_accept"},  int'(busy),         (v.n != 0) ? 1 : 0);
    chk({tag, "_ready_accept"}, int'(target_ready), (v.n != 0) ? 0 : 1);
    if (v.n == 0) begin
      repeat (300) begin
        tick();
        if (busy || duty != prev) break;
      end
      chk({tag, "_duty_hold"}, int'(duty), int'(prev));
      chk({tag, "_busy_hold"}, int'(busy), 0);
    end
    for (int i = 0; i < v.n; i++) begin
      wait_change(1'b0, prev, 600, cyc, ok);
      chk({tag, "_timeout"}, int'(ok), 1);
      chk({tag, "_duty"}, int'(duty), int'(v.seq[8*i +: 8]));
      chk({tag, "_phase0"}, int'(dut.u_timer.phase), 0);
      if (i > 0) chk({tag, "_spacing"}, cyc, 256);
      chk({tag, "_busy"}, int'(busy), (i == v.n - 1) ? 0 : 1);
      prev = duty;
    end
    chk({tag, "_ready_post"}, int'(target_ready), 1);
  endtask

  // Ramp to an endpoint, checking each step against a saturating model.
  task automatic run_endpoint(input logic [7:0] tgt, input string tag);
    logic [7:0] prev, exp;
    int cyc, steps;
    bit ok;
    prev         = duty;
    target       = tgt;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    steps = 0;
    while (prev != tgt && steps < 40) begin
      if (tgt > prev) exp = (int'(tgt) - int'(prev) > 8) ? prev + 8'd8 : tgt;
      else            exp = (int'(prev) - int'(tgt) > 8) ? prev - 8'd8 : tgt;
      wait_change(1'b0, prev, 600, cyc, ok);
      chk({tag, "_timeout"}, int'(ok), 1);
      chk({tag, "_step"}, int'(duty), int'(exp));
      if (!ok) break;
      prev = duty;
      steps++;
    end
    chk({tag, "_final"}, int'(duty), int'(tgt));
    chk({tag, "_busy_end"}, int'(busy), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int  cyc;
    bit  ok;
    logic [7:0] prev;

    vecs[0] = '{target: 8'd51, n: 7, seq: {8'd0, 8'd51, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8}};
    vecs[1] = '{target: 8'd51, n: 0, seq: 64'd0};
    vecs[2] = '{target: 8'd10, n: 6, seq: {8'd0, 8'd0, 8'd10, 8'd11, 8'd19, 8'd27, 8'd35, 8'd43}};
    vecs[3] = '{target: 8'd0,  n: 2, seq: {48'd0, 8'd0, 8'd2}};
    vecs[4] = '{target: 8'd20, n: 3, seq: {40'd0, 8'd20, 8'd16, 8'd8}};

    reset = 1'b1;
    target = '0; target_valid = 1'b0;
    target_d = '0; target_valid_d = 1'b0;
    repeat (3) tick();

    // Reset state, both instances.
    chk("rst_duty",   int'(duty), 0);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_ready",  int'(target_ready), 1);
    chk("rst_pstart", int'(period_start), 0);
    chk("rst_phase",  int'(dut.u_timer.phase), 0);
    chk("rst_duty_d", int'(duty_d), 0);
    chk("rst_busy_d", int'(busy_d), 0);
    chk("rst_ready_d", int'(target_ready_d), 1);

    // Default parameters: 0 -> 2, accepted on the first edge after reset.
    reset          = 1'b0;
    target_d       = 8'd2;
    target_valid_d = 1'b1;
    tick();
    target_valid_d = 1'b0;
    chk("def_busy_accept",  int'(busy_d), 1);
    chk("def_ready_accept", int'(target_ready_d), 0);
    wait_change(1'b1, 8'd0, 1100, cyc, ok);
    chk("def_timeout1", int'(ok), 1);
    chk("def_first_cyc", cyc, 1023);   // duty=1 at 1024 clocks from reset release
    chk("def_duty1", int'(duty_d), 1);
    chk("def_busy1", int'(busy_d), 1);
    wait_change(1'b1, 8'd1, 1100, cyc, ok);
    chk("def_timeout2", int'(ok), 1);
    chk("def_second_cyc", cyc, 1024);
    chk("def_duty2", int'(duty_d), 2);
    chk("def_busy2", int'(busy_d), 0);
    chk("def_ready2", int'(target_ready_d), 1);

    // Table: up-ramp, equal target, down-ramp, down to 0, up to 20.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Retarget ignored: 20 -> 51, pulse 200 mid-ramp.
    target       = 8'd51;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    wait_change(1'b0, 8'd20, 600, cyc, ok);
    chk("rt_first_step", int'(duty), 28);
    target       = 8'd200;
    target_valid = 1'b1;
    repeat (5) begin
      chk("rt_ready_low", int'(target_ready), 0);
      tick();
    end
    target_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("rt_busy_end", int'(busy), 0);
    chk("rt_final", int'(duty), 51);
    repeat (300) tick();
    chk("rt_hold", int'(duty), 51);
    chk("rt_hold_busy", int'(busy), 0);

    // Endpoints without wrap.
    run_endpoint(8'd255, "up255");
    run_endpoint(8'd0, "down0");

    // Reset mid-ramp at duty 24, with a simultaneous target_valid on both.
    target       = 8'd51;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    prev = duty;
    for (int i = 0; i < 3; i++) begin
      wait_change(1'b0, prev, 600, cyc, ok);
      prev = duty;
    end
    chk("mr_duty24", int'(duty), 24);
    reset          = 1'b1;
    target         = 8'd99;
    target_valid   = 1'b1;
    target_d       = 8'd99;
    target_valid_d = 1'b1;
    tick();
    chk("mr_duty",    int'(duty), 0);
    chk("mr_busy",    int'(busy), 0);
    chk("mr_ready",   int'(target_ready), 1);
    chk("mr_phase",   int'(dut.u_timer.phase), 0);
    chk("mr_duty_d",  int'(duty_d), 0);
    chk("mr_busy_d",  int'(busy_d), 0);
    chk("mr_ready_d", int'(target_ready_d), 1);
    reset          = 1'b0;
    target_valid   = 1'b0;
    target_valid_d = 1'b0;
    repeat (300) tick();
    chk("mr_idle_duty", int'(duty), 0);
    chk("mr_idle_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/duty_ramp.md
# duty_ramp

Upstream stage for the 8-bit PWM generator: it accepts a target duty value over a valid/ready handshake and drives the PWM `duty` input, slewing toward the target in bounded steps. Steps are applied only at PWM period boundaries, so the PWM never sees a mid-period duty change. Typical use is soft-start and soft-change of an LED or motor drive, for example 51 → 10 without a step jump.

## Interface
Parameters:
- `STEP`, 1: maximum duty change per step (1..255).
- `PERIODS_PER_STEP`, 4: PWM periods between steps (1..255).
- `RESET_DUTY`, 0: `duty` value after reset.

Ports:
- `clk` in 1: single clock, same clock as the PWM block.
- `reset` in 1: synchronous, active-high.
- `target` in 8: requested duty, 0..255.
- `target_valid` in 1: `target` is presented.
- `target_ready` out 1: block accepts a new target.
- `duty` out 8: registered; connects directly to the PWM `duty` input.
- `period_start` out 1: one-cycle pulse on the last clock of each 256-clock PWM period.
- `busy` out 1: a ramp is in progress.

## Operation
- Phase counter: 8 bits, free-running 0..255, wraps to 0. It mirrors the PWM period of 256 clocks. `period_start` = (phase == 255).
- FSM states:
  - IDLE: `target_ready`=1, `busy`=0. On `target_valid && target_ready`, latch `target` into `tgt_q` and clear the period counter. If `tgt_q == duty`, stay in IDLE; otherwise go to RAMP.
  - RAMP: `target_ready`=0, `busy`=1. `target_valid` is ignored; no retargeting mid-ramp. The period counter increments on each `period_start`.
- Step rule: on a `period_start` cycle where the period counter == `PERIODS_PER_STEP`−1:
  - Clear the period counter.
  - `duty` ← `duty` ± min(`STEP`, |`tgt_q` − `duty`|), using 9-bit signed difference.
  - There is no overshoot and no wrap: `duty` saturates exactly at `tgt_q`.
- When the updated `duty` equals `tgt_q`, return to IDLE on the same edge.
- `duty` changes only on edges where phase goes 255→0.

## Timing
- Reset values: `duty`=`RESET_DUTY`, phase=0, period counter=0, state IDLE, `target_ready`=1, `busy`=0, `period_start`=0.
- Acceptance at edge k: `busy`=1 and `target_ready`=0 from cycle k+1.
- First duty change occurs at the `PERIODS_PER_STEP`-th `period_start` after acceptance.
- Step spacing is exactly `PERIODS_PER_STEP`×256 clocks.
- Ramp end: `busy` and `target_ready` flip in the cycle after the final `duty` update.
- A new target can be accepted in that same cycle.
- Target equal to the current `duty`: accepted, `busy` never asserts, `target_ready` stays 1.
- Reset mid-ramp: all state returns to reset values on the next edge. `duty` jumps to `RESET_DUTY` and the ramp is abandoned.
- Reset has priority over a simultaneous `target_valid`.

## Structure
- Package `pwm_pkg`:
  - `DUTY_W`=8
  - `PHASE_MAX`=8'd255
  - `ramp_state_t` enum {IDLE, RAMP}
- Sub-module `period_timer`: phase counter plus `period_start` generation, reusable by other PWM-side stages.
- Top level: FSM, period counter, `tgt_q`/`duty` registers, saturating step arithmetic.

## Test plan
All scenarios use `STEP`=8 and `PERIODS_PER_STEP`=1 unless stated.
- Up-ramp: from reset (`duty`=0), target 51.
  - `duty` sequence: 8, 16, 24, 32, 40, 48, 51.
  - Each change occurs on a 255→0 phase edge, 256 clocks apart.
  - `busy` clears after 51.
- Down-ramp: from 51, target 10.
  - `duty` sequence: 43, 35, 27, 19, 11, 10.
  - No value below 10.
- Retarget ignored: during the 0→51 ramp, pulse `target_valid` with 200.
  - `target_ready` reads 0; the ramp still ends at 51.
- Equal target: in IDLE with `duty`=51, present 51.
  - Handshake completes, `busy` stays 0, `duty` unchanged.
- Reset mid-ramp: assert `reset` when `duty`=24.
  - Next cycle: `duty`=0, `busy`=0, `target_ready`=1, phase=0.
- Defaults (`STEP`=1, `PERIODS_PER_STEP`=4): 0→2.
  - `duty`=1 after 1024 clocks, `duty`=2 after 2048 clocks.
  - Endpoints: 0→255 reaches 255 and 255→0 reaches 0, each with no wrap-around.
